id_operand_stage: RTL and testbench

- Decode/register-read stage that sits directly upstream of the 32-bit ALU.
- Holds the 32-entry register file and decodes a MIPS-subset instruction into ALU operands a/b and a 3-bit ALU op. The op encoding is: op[2] = subtract; op[1:0] selects 00 and, 01 or, 10 add/sub, 11 slt.
- Captures its results in a one-entry output register with a valid/ready handshake to the execute stage. Accepts register write-back from downstream.

---
 rtl/id_operand_stage_if.sv | 37 +++
 rtl/id_operand_stage.sv | 195 +++++++++++++++++++
 tb/tb_id_operand_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_if.sv
// Bundle between the decode/operand stage, its instruction feeder and the ALU.
// The slave modport is the stage itself; the master modport is its environment.
interface id_operand_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;

  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [4:0]        rd_out;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] store_data;
  logic              illegal;

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd_out,
           reg_write, mem_read, mem_write, store_data, illegal
  );

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd_out,
           reg_write, mem_read, mem_write, store_data, illegal
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/register-read stage ahead of the ALU: 32-entry register file, MIPS-subset
// decode and a one-entry output register. Define ID_WB_BYPASS_EN to forward same-cycle write-back.
module id_operand_stage #(
  parameter int DATA_W    = 32,
  parameter bit REG_CLEAR = 1'b1
) (
  input logic               clk,
  input logic               reset,
  id_operand_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [DATA_W-1:0] regs [32];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              wb_hit;
  logic              unused_shamt;

  logic              ready;
  logic              accept;

  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;
  logic [2:0]        d_op;
  logic [4:0]        d_rd;
  logic              d_rw;
  logic              d_mr;
  logic              d_mw;
  logic [DATA_W-1:0] d_sd;
  logic              d_ill;

  logic              q_valid;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic [2:0]        q_op;
  logic [4:0]        q_rd;
  logic              q_rw;
  logic              q_mr;
  logic              q_mw;
  logic [DATA_W-1:0] q_sd;
  logic              q_ill;

  assign opcode       = bus.instr[31:26];
  assign rs           = bus.instr[25:21];
  assign rt           = bus.instr[20:16];
  assign rd           = bus.instr[15:11];
  assign funct        = bus.instr[5:0];
  assign unused_shamt = ^bus.instr[10:6];
  assign imm_sext     = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};

  assign ready  = !q_valid || bus.out_ready;
  assign accept = bus.in_valid && ready;
  assign wb_hit = bus.wb_en && (bus.wb_addr != 5'd0);

  // Register file keeps its contents through reset unless REG_CLEAR is set.
  always_ff @(posedge clk) begin
    if (reset && REG_CLEAR) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rs_val = (rs == 5'd0) ? '0 : regs[rs];
    rt_val = (rt == 5'd0) ? '0 : regs[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_hit && (bus.wb_addr == rs)) rs_val = bus.wb_data;
    if (wb_hit && (bus.wb_addr == rt)) rt_val = bus.wb_data;
`endif
  end

  always_comb begin
    d_a   = rs_val;
    d_b   = rt_val;
    d_op  = ALU_AND;
    d_rd  = '0;
    d_rw  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_sd  = '0;
    d_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_rd = rd;
        d_rw = 1'b1;
        case (funct)
          FN_ADD:  d_op = ALU_ADD;
          FN_SUB:  d_op = ALU_SUB;
          FN_AND:  d_op = ALU_AND;
          FN_OR:   d_op = ALU_OR;
          FN_SLT:  d_op = ALU_SLT;
          default: begin
            d_rd  = '0;
            d_rw  = 1'b0;
            d_ill = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        d_op = ALU_ADD;
        d_b  = imm_sext;
        d_rd = rt;
        d_rw = 1'b1;
      end
      OP_LW: begin
        d_op = ALU_ADD;
        d_b  = imm_sext;
        d_rd = rt;
        d_rw = 1'b1;
        d_mr = 1'b1;
      end
      OP_SW: begin
        d_op = ALU_ADD;
        d_b  = imm_sext;
        d_mw = 1'b1;
        d_sd = rt_val;
      end
      OP_BEQ: begin
        d_op = ALU_SUB;
      end
      default: begin
        d_ill = 1'b1;
      end
    endcase
  end

  // Bundle payload only loads on accept, so a stalled bundle ignores later write-backs.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_a     <= '0;
      q_b     <= '0;
      q_op    <= '0;
      q_rd    <= '0;
      q_rw    <= 1'b0;
      q_mr    <= 1'b0;
      q_mw    <= 1'b0;
      q_sd    <= '0;
      q_ill   <= 1'b0;
    end else if (accept) begin
      q_valid <= 1'b1;
      q_a     <= d_a;
      q_b     <= d_b;
      q_op    <= d_op;
      q_rd    <= d_rd;
      q_rw    <= d_rw;
      q_mr    <= d_mr;
      q_mw    <= d_mw;
      q_sd    <= d_sd;
      q_ill   <= d_ill;
    end else if (bus.out_ready) begin
      q_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = q_valid;
  assign bus.alu_a      = q_a;
  assign bus.alu_b      = q_b;
  assign bus.alu_op     = q_op;
  assign bus.rd_out     = q_rd;
  assign bus.reg_write  = q_rw;
  assign bus.mem_read   = q_mr;
  assign bus.mem_write  = q_mw;
  assign bus.store_data = q_sd;
  assign bus.illegal    = q_ill;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed scenarios, then randomized traffic
// checked against a behavioural decode/register model.
module tb_id_operand_stage;
  localparam int DATA_W    = 32;
  localparam bit REG_CLEAR = 1'b1;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    bit          chk_ab;
    bit          chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DATA_W(DATA_W)) bus ();

  id_operand_stage #(.DATA_W(DATA_W), .REG_CLEAR(REG_CLEAR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t        q[$];
  logic [31:0] m_regs [32];
  bit          m_valid;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && we && wa == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] va, vb, sx;
    va = rdreg(ins[25:21], we, wa, wd);
    vb = rdreg(ins[20:16], we, wa, wd);
    sx = {{16{ins[15]}}, ins[15:0]};
    e = '{a: va, b: vb, sd: 32'd0, op: 3'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
          ill: 1'b0, chk_ab: 1'b1, chk_rd: 1'b1};
    case (ins[31:26])
      6'h00: begin
        e.rd = ins[15:11];
        e.rw = 1'b1;
        case (ins[5:0])
          6'h20: e.op = 3'd2;
          6'h22: e.op = 3'd6;
          6'h24: e.op = 3'd0;
          6'h25: e.op = 3'd1;
          6'h2A: e.op = 3'd7;
          default: begin
            e.rw = 1'b0; e.ill = 1'b1; e.chk_ab = 1'b0; e.chk_rd = 1'b0;
          end
        endcase
      end
      6'h08: begin e.op = 3'd2; e.b = sx; e.rd = ins[20:16]; e.rw = 1'b1; end
      6'h23: begin e.op = 3'd2; e.b = sx; e.rd = ins[20:16]; e.rw = 1'b1; e.mr = 1'b1; end
      6'h2B: begin e.op = 3'd2; e.b = sx; e.mw = 1'b1; e.sd = vb; e.chk_rd = 1'b0; end
      6'h04: begin e.op = 3'd6; end
      default: begin e.ill = 1'b1; e.chk_ab = 1'b0; e.chk_rd = 1'b0; end
    endcase
    return e;
  endfunction

  // Inputs are applied just after a negedge; the next posedge consumes them.
  task automatic cycle(input logic rst, input logic iv, input logic [31:0] ins,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
    bit exp_rdy, acc;
    reset         = rst;
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.out_ready = ordy;
    #1;
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      if (REG_CLEAR) for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      exp_rdy = !m_valid || ordy;
      n_vec++;
      if (bus.in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL in_ready at %0t: got %b want %b", $time, bus.in_ready, exp_rdy);
      end
      acc = iv && exp_rdy;
      if (acc) q.push_back(model(ins, we, wa, wd));
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (acc) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset();
    n_vec++;
    if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd_out, bus.reg_write,
         bus.mem_read, bus.mem_write, bus.store_data, bus.illegal} !== '0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b a=%h b=%h op=%b rd=%0d rw=%b mr=%b mw=%b sd=%h ill=%b rdy=%b, want all 0 and rdy=1",
               bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd_out, bus.reg_write,
               bus.mem_read, bus.mem_write, bus.store_data, bus.illegal, bus.in_ready);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5];
    logic [5:0] bad_ops [4];
    logic [31:0] r;
    int k;
    fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad_ops = '{6'h3F, 6'h02, 6'h0C, 6'h0F};
    r = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0, 1, 2, 3, 4: return {6'h00, r[25:6], fns[k]};
      5:       return {6'h08, r[25:0]};
      6:       return {6'h23, r[25:0]};
      7:       return {6'h2B, r[25:0]};
      8:       return {6'h04, r[25:0]};
      9:       return {bad_ops[$urandom_range(0, 3)], r[25:0]};
      default: return {6'h00, r[25:6], 6'h21};
    endcase
  endfunction

  // Monitor: samples after the driver settles, compares against the queue head.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      #3;
      if (reset) continue;
      if (bus.out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL bundle at %0t: out_valid=1 but no bundle expected", $time);
        end else begin
          e  = q[0];
          ok = (bus.alu_op === e.op) && (bus.reg_write === e.rw) && (bus.mem_read === e.mr) &&
               (bus.mem_write === e.mw) && (bus.store_data === e.sd) && (bus.illegal === e.ill) &&
               (!e.chk_ab || (bus.alu_a === e.a && bus.alu_b === e.b)) &&
               (!e.chk_rd || bus.rd_out === e.rd);
          if (!ok) begin
            n_err++;
            $display("FAIL bundle at %0t: got a=%h b=%h op=%b rd=%0d rw=%b mr=%b mw=%b sd=%h ill=%b; want a=%h b=%h op=%b rd=%0d rw=%b mr=%b mw=%b sd=%h ill=%b",
                     $time, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd_out, bus.reg_write,
                     bus.mem_read, bus.mem_write, bus.store_data, bus.illegal,
                     e.a, e.b, e.op, e.rd, e.rw, e.mr, e.mw, e.sd, e.ill);
          end
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit rst_r, iv_r, we_r, or_r;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;

    cycle(1, 0, 32'd0, 0, 5'd0, 32'd0, 1);
    cycle(1, 0, 32'd0, 0, 5'd0, 32'd0, 1);
    check_reset();

    cycle(0, 0, 32'd0, 1, 5'd1, 32'd5, 1);
    cycle(0, 0, 32'd0, 1, 5'd2, 32'd3, 1);
    cycle(0, 1, 32'h00221820, 0, 5'd0, 32'd0, 1);
    cycle(0, 1, 32'h2004FFFF, 0, 5'd0, 32'd0, 1);
    cycle(0, 1, 32'hAC220008, 0, 5'd0, 32'd0, 1);

    for (int i = 0; i < 3; i++) cycle(0, 1, rtype(5'd1, 5'd2, 5'd9, 6'h24), 0, 5'd0, 32'd0, 0);
    cycle(0, 1, rtype(5'd1, 5'd2, 5'd9, 6'h24), 0, 5'd0, 32'd0, 1);
    cycle(0, 1, 32'h10220004, 0, 5'd0, 32'd0, 1);

    cycle(0, 1, rtype(5'd1, 5'd2, 5'd5, 6'h22), 1, 5'd1, 32'd9, 1);
    cycle(0, 0, 32'd0, 1, 5'd0, 32'h0000DEAD, 1);
    cycle(0, 1, rtype(5'd0, 5'd0, 5'd6, 6'h25), 0, 5'd0, 32'd0, 1);
    cycle(0, 1, 32'hFC000000, 0, 5'd0, 32'd0, 1);
    cycle(0, 1, rtype(5'd1, 5'd2, 5'd7, 6'h2A), 0, 5'd0, 32'd0, 1);
    cycle(0, 1, 32'h8C23FFF0, 0, 5'd0, 32'd0, 1);

    cycle(0, 1, rtype(5'd1, 5'd2, 5'd7, 6'h20), 0, 5'd0, 32'd0, 0);
    cycle(0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    cycle(1, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    check_reset();
    cycle(0, 1, rtype(5'd1, 5'd0, 5'd8, 6'h25), 0, 5'd0, 32'd0, 1);
    cycle(0, 0, 32'd0, 0, 5'd0, 32'd0, 1);

    for (int i = 1; i < 32; i++) cycle(0, 0, 32'd0, 1, 5'(i), $urandom, 1);

    for (int n = 0; n < 600; n++) begin
      rst_r = ($urandom_range(0, 199) == 0);
      iv_r  = ($urandom_range(0, 9) < 7);
      we_r  = ($urandom_range(0, 1) == 1);
      or_r  = ($urandom_range(0, 9) < 7);
      if (rst_r) begin
        cycle(1, 0, 32'd0, 0, 5'd0, 32'd0, or_r);
        check_reset();
      end else begin
        cycle(0, iv_r, rand_instr(), we_r, 5'($urandom_range(0, 31)), $urandom, or_r);
      end
    end

    for (int i = 0; i < 4; i++) cycle(0, 0, 32'd0, 0, 5'd0, 32'd0, 1);
    n_vec++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: %0d bundles never delivered, out_valid=%b, want 0 and 0", q.size(), bus.out_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
